clk_dncnt_timer: RTL
====================

# clk_dncnt_timer

Programmable down-counting timer built on the team's `fa` full-adder cell: decrement is a WIDTH-bit ripple chain adding all-ones. It loads a start value and counts to zero, one step per prescaler tick. On reaching zero it emits a terminal-count pulse and either stops or auto-reloads. It complements the up/down demo counter: that block consumes a direction bit, while this one produces timed events (timeouts, periodic strobes) for the rest of the testbench designs.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRE_W, 4, prescaler width in bits (≥1)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- start  input  1  level sampled each edge; loads `load_val` and starts counting
- stop  input  1  aborts counting; wins over `start` in the same cycle
- load_val  input  WIDTH  start/reload value, captured only when `start` is accepted
- prescale  input  PRE_W  tick period minus one, captured when `start` is accepted
- reload_en  input  1  auto-reload at terminal count; sampled live at each terminal event
- cnt  output  WIDTH  current count (registered)
- tc  output  1  one-cycle terminal-count pulse (registered)
- busy  output  1  high while in RUN (registered)

## Operation
- Reset: when `reset`=1 at an edge, the block goes to IDLE with cnt=0, tc=0, busy=0, prescaler=0, captured reload value=0, and captured prescale=0. Reset overrides all other inputs, including mid-count.
- States: IDLE and RUN. `busy` = (state==RUN).
- IDLE:
  - `start`=1, `stop`=0, load_val≠0 → cnt←load_val, reload reg←load_val, pre←prescale, go to RUN.
  - `start`=1 with load_val=0 → cnt←0, stay in IDLE, no tc.
  - Otherwise cnt holds.
- RUN, in priority order:
  - `stop`=1 → go to IDLE, cnt frozen at its current value, tc=0.
  - Else `start`=1 → restart exactly as from IDLE. The prescaler restarts, and load_val=0 goes to IDLE.
  - Else if pre≠0 → pre←pre−1.
  - Else (tick): pre←captured prescale, then:
    - cnt>1 → cnt←cnt−1.
    - cnt==1 → terminal event: tc←1. If reload_en=1, cnt←reload reg and stay in RUN. Otherwise cnt←0 and go to IDLE.
- Decrement arithmetic: WIDTH `fa` instances with a=cnt[i], b=1, ci chained, ci[0]=0; s gives cnt−1. The carry-out of the MSB is 0 iff cnt==0. It must never be 0 in RUN; if it is, that is an assertion failure for the bench.
- Zero is never wrapped: cnt does not go 0→all-ones.
- tc is high for exactly one cycle per terminal event and is 0 in every other cycle.

## Timing
- `start` accepted at edge t: cnt=load_val and busy=1 are visible after edge t.
- With P=prescale: decrements occur at edges t+(P+1), t+2(P+1), …
- With L=load_val: tc is high in the cycle following edge t+L·(P+1), coincident with cnt=0 (or cnt=L on reload).
- busy falls at the same edge when there is no reload.
- Auto-reload period: exactly L·(P+1) clocks between tc pulses, with no dead cycle.
- L=1: the first tick is the terminal event.
- P=0: the count moves every clock.
- `stop` at edge s: busy=0 after s, and no tc is produced at s even if s is a tick edge.
- `start` on the same edge as a terminal event: the restart wins and tc=0.
- Changing prescale, load_val, or reload_en mid-run:
  - prescale and load_val have no effect until the next accepted `start`.
  - reload_en is sampled at the terminal edge.

## Test plan
- Reset then idle: reset for 2 cycles → cnt=0, tc=0, busy=0. Hold 10 cycles with no start → unchanged.
- One-shot: start with load_val=5, prescale=0, reload_en=0 → cnt 5,4,3,2,1,0 on consecutive clocks. tc high only in the cycle cnt=0, busy drops at that edge, and no further change for 20 cycles.
- Prescaled auto-reload: load_val=3, prescale=2, reload_en=1 → cnt steps every 3 clocks, tc pulses exactly every 9 clocks, and cnt shows 3 in the tc cycle. Drop reload_en before the third event → that event gives cnt=0, busy=0, and the final tc.
- Stop/start priority: mid-run at cnt=4, assert stop and start together → IDLE, cnt=4 frozen, no tc. A later start with load_val=0 → cnt=0, busy=0, no tc.
- Boundary width: WIDTH=8, load_val=255, prescale=0 → tc exactly 255 clocks after start. load_val=1 → tc one clock after start. MSB carry-out of the `fa` chain is never 0 in RUN.
- Reset mid-operation: assert reset at cnt=7 on a tick edge → next cycle cnt=0, busy=0, tc=0. Release reset and start with load_val=2 → normal count with tc after 2·(P+1) clocks.

Source files
------------

// File: rtl/clk_dncnt_timer_if.sv
// clk_dncnt_timer_if: control/status bundle for the down-counting timer.
//   start, stop      : command levels (stop wins over start)
//   load_val         : start/reload value, captured on an accepted start
//   prescale         : tick period minus one, captured on an accepted start
//   reload_en        : auto-reload select, sampled at each terminal event
//   cnt, tc, busy    : registered count, terminal-count pulse, run flag
// master = the side issuing commands, slave = the timer.
interface clk_dncnt_timer_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic             reload_en;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             busy;

    modport master (
        output start, stop, load_val, prescale, reload_en,
        input  cnt, tc, busy
    );

    modport slave (
        input  start, stop, load_val, prescale, reload_en,
        output cnt, tc, busy
    );
endinterface

// File: rtl/clk_dncnt_timer.sv
// fa: one-bit full-adder cell.
//   a, b, ci : addends and carry in
//   s, co    : sum and carry out
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// clk_dncnt_timer: programmable down-counter with prescaler, terminal-count
// pulse and optional auto-reload.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : command/status bundle (slave side)
module clk_dncnt_timer #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    clk_dncnt_timer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] rld_q, rld_n;
    logic [PRE_W-1:0] pre_q, pre_n;
    logic [PRE_W-1:0] pscl_q, pscl_n;
    logic             tc_q, tc_n;

    // Decrement as cnt + all-ones through a ripple of fa cells. The MSB
    // carry-out is 1 for any nonzero cnt, so it doubles as a nonzero flag.
    logic [WIDTH-1:0] dec;
    logic [WIDTH:0]   carry;
    logic             co_msb;

    assign carry[0] = 1'b0;

    fa u_fa [WIDTH-1:0] (
        .a  (cnt_q),
        .b  ({WIDTH{1'b1}}),
        .ci (carry[WIDTH-1:0]),
        .s  (dec),
        .co (carry[WIDTH:1])
    );

    assign co_msb = carry[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt_q  <= '0;
            rld_q  <= '0;
            pre_q  <= '0;
            pscl_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt_q  <= cnt_n;
            rld_q  <= rld_n;
            pre_q  <= pre_n;
            pscl_q <= pscl_n;
            tc_q   <= tc_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt_q;
        rld_n   = rld_q;
        pre_n   = pre_q;
        pscl_n  = pscl_q;
        tc_n    = 1'b0;

        // A start from RUN behaves exactly like a start from IDLE, so both
        // states share the load path; stop has already been ruled out.
        if (bus.start && !bus.stop) begin
            if (bus.load_val != '0) begin
                cnt_n   = bus.load_val;
                rld_n   = bus.load_val;
                pre_n   = bus.prescale;
                pscl_n  = bus.prescale;
                state_n = RUN;
            end else begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        end else if (state == RUN) begin
            if (bus.stop) begin
                state_n = IDLE;
            end else if (pre_q != '0) begin
                pre_n = pre_q - PRE_W'(1);
            end else begin
                pre_n = pscl_q;
                if (cnt_q != WIDTH'(1)) begin
                    cnt_n = dec;
                end else begin
                    tc_n = 1'b1;
                    if (bus.reload_en) begin
                        cnt_n = rld_q;
                    end else begin
                        cnt_n   = dec;
                        state_n = IDLE;
                    end
                end
            end
        end
    end

    // RUN is only ever entered with a nonzero count and left on reaching
    // zero, so a zero count inside RUN means the control logic is broken.
    always_ff @(posedge clk) begin
        if (!reset && state == RUN) begin
            assert (co_msb);
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.tc   = tc_q;
    assign bus.busy = (state == RUN);
endmodule
